instr_prefetch_mem: RTL and testbench
=====================================

INSTR_PREFETCH_MEM -- requirements
Module: instr_prefetch_mem

Interface
REQ-001 Parameter BYTE_W, default 4: bytes per instruction word.
REQ-002 Parameter ADDR_W, default 8: byte-address width; memory holds 2^ADDR_W bytes.
REQ-003 Parameter FIFO_DEPTH, default 4: prefetch queue entries, a power of two and at least 2.
REQ-004 Parameter INIT_FILE, default "": hex byte image loaded at elaboration when non-empty.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that begins fetching at start_addr.
REQ-008 start_addr  in  ADDR_W  initial fetch byte address.
REQ-009 flush  in  1  redirect request (taken branch).
REQ-010 flush_addr  in  ADDR_W  redirect target byte address.
REQ-011 out_valid  out  1  out_instr and out_pc hold a valid entry.
REQ-012 out_ready  in  1  consumer accepts the entry.
REQ-013 out_instr  out  8*BYTE_W  fetched instruction word.
REQ-014 out_pc  out  ADDR_W  byte address of out_instr.
REQ-015 busy  out  1  asserted while in RUN or REDIRECT.

Function
REQ-016 Bytes SHALL be stored little-endian: out_instr[8i+:8] = mem[pc+i] for i = 0..BYTE_W-1, with byte addresses wrapping modulo 2^ADDR_W.
REQ-017 The FSM SHALL have three states: IDLE (reset state), RUN and REDIRECT.
REQ-018 IDLE -> RUN on start; fetch pc <= start_addr with the low log2(BYTE_W) bits forced to 0.
REQ-019 In RUN, one synchronous read SHALL issue per cycle when the count of queued plus in-flight words is below FIFO_DEPTH; pc then increments by BYTE_W and wraps.
REQ-020 Read latency SHALL be 1 cycle into the FIFO; out_valid SHALL rise 2 cycles after the start pulse.
REQ-021 A transfer occurs when out_valid and out_ready are both high; out_instr and out_pc SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 On flush (RUN or REDIRECT), the FIFO SHALL clear on the next edge, the in-flight read SHALL be discarded, pc <= aligned flush_addr, and the state SHALL enter REDIRECT for 1 cycle before returning to RUN.
REQ-023 If flush and a transfer coincide, flush SHALL win and the entry SHALL be dropped; the consumer treats it as not delivered.
REQ-024 A flush in IDLE SHALL be ignored. A start outside IDLE SHALL be ignored.
REQ-025 With the FIFO full, no read SHALL issue and pc SHALL hold; there is no overflow and no lost word.
REQ-026 When the FIFO is empty, out_valid SHALL be 0; out_instr and out_pc hold their last values.

Reset
REQ-027 When rst_n is low: state=IDLE, pc=0, FIFO empty, in-flight flag=0, out_valid=0, out_instr=0, out_pc=0, busy=0.
REQ-028 Reset mid-RUN SHALL discard all queued and in-flight words; memory contents SHALL be preserved.

Configuration
REQ-029 With IMEM_LOADER_EN defined, ports wr_en (1), wr_addr (ADDR_W) and wr_byte (8) SHALL exist; they write one byte per cycle, accepted in IDLE only.
REQ-030 Without IMEM_LOADER_EN, the write ports SHALL be absent and the memory SHALL be read-only, initialised from INIT_FILE alone.

Structure
REQ-031 The package imem_pkg SHALL hold the state enum (IDLE, RUN, REDIRECT) and the default BYTE_W/ADDR_W constants.
REQ-032 The FIFO SHALL be the sub-module imem_fifo (parameters WIDTH, DEPTH; push/pop/clear; full/empty/count).

Verification
REQ-033 Preload bytes 00 10 12 E4 at address 0, start with start_addr=0, out_ready=1 -> out_valid at cycle 2 with out_instr=32'hE4121000 and out_pc=0, then out_pc 4, 8, ... one per cycle.
REQ-034 Hold out_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries queue, pc stalls, out_instr stays stable; on release the words arrive in order with none lost.
REQ-035 flush with flush_addr=8'h2E while out_ready=1 -> the coincident entry is dropped, and the next delivered out_pc is 8'h2C with no stale words.
REQ-036 start with start_addr=8'hFC, ADDR_W=8 -> out_pc sequence FC, 00, 04; out_instr at FC assembles mem[FC..FF].
REQ-037 Assert rst_n=0 mid-RUN with 3 words queued -> out_valid=0 immediately; after release, state=IDLE and a new start refetches correct data.
REQ-038 IMEM_LOADER_EN: write 8'hAB at address 3 in IDLE, then start at 0 -> out_instr[31:24]=8'hAB; the same write during RUN is ignored.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction prefetch memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

   // Fetch controller states; IDLE is the reset state.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } state_t;

   localparam int BYTE_W_DEF = 4;  // bytes per instruction word
   localparam int ADDR_W_DEF = 8;  // byte-address width

endpackage

// File: rtl/imem_fifo.sv
// Generic synchronous FIFO holding prefetched {pc, instr} entries.
// Latency: a push is visible at head_dat after the next rising edge.
// Backpressure: push is ignored when full, pop when empty; clear empties it and wins over push/pop.
//
// Ports: clk, rst_n (async active-low); push/push_dat write side;
//        pop/head_dat read side (head_dat is the oldest entry);
//        clear flushes all entries; full, empty, count report occupancy.
module imem_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   input  logic                       clear,
   output logic [WIDTH-1:0]           head_dat,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = store[rd_ptr];

   // Storage carries no reset: only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         store[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_prefetch_mem.sv
// Byte-addressed instruction memory with a sequential prefetcher feeding a small queue.
// Latency: out_valid rises two cycles after the start pulse (1-cycle read + 1 cycle into the queue).
// Backpressure: valid/ready; reads stop once queued + in-flight words reach FIFO_DEPTH, pc holds, no words lost.
//
// Ports: clk, rst_n (async active-low); start/start_addr begin fetching from IDLE;
//        flush/flush_addr redirect fetching (taken branch) and drop everything queued;
//        out_valid/out_ready/out_instr/out_pc deliver little-endian words with their byte address;
//        busy is high in RUN or REDIRECT.
// Build option IMEM_LOADER_EN adds wr_en/wr_addr/wr_byte, a byte write port accepted only in IDLE.
// Without it the memory is read-only.
module instr_prefetch_mem
   import imem_pkg::*;
#(
   parameter int    BYTE_W     = BYTE_W_DEF,
   parameter int    ADDR_W     = ADDR_W_DEF,
   parameter int    FIFO_DEPTH = 4,
   parameter string INIT_FILE  = ""
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     start_addr,
   input  logic                  flush,
   input  logic [ADDR_W-1:0]     flush_addr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*BYTE_W-1:0]   out_instr,
   output logic [ADDR_W-1:0]     out_pc,
   output logic                  busy
`ifdef IMEM_LOADER_EN
   ,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [7:0]            wr_byte
`endif
);
   localparam int WORD_W = 8 * BYTE_W;
   localparam int ENT_W  = WORD_W + ADDR_W;
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTE_W - 1);
   localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(BYTE_W);

   logic [7:0]        mem [0:(1<<ADDR_W)-1];

   state_t            state;
   logic [ADDR_W-1:0] pc;          // next address to fetch
   logic              inflight;    // rd_word/rd_pc hold a read issued last cycle
   logic [WORD_W-1:0] rd_word;
   logic [ADDR_W-1:0] rd_pc;

   logic              flush_act;
   logic              credit_ok;
   logic              rd_issue;
   logic [ADDR_W-1:0] fetch_addr;
   logic [WORD_W-1:0] fetch_word;

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [ENT_W-1:0]  head_dat;
   logic [ENT_W-1:0]  last_dat;
   logic [ENT_W-1:0]  shown_dat;

`ifdef IMEM_LOADER_EN
   always_ff @(posedge clk) begin
      if (wr_en && state == IDLE) begin
         mem[wr_addr] <= wr_byte;
      end
   end
`endif

   // Flush only matters once fetching has started.
   assign flush_act = flush && (state != IDLE);
   assign credit_ok = !fifo_full && ((int'(fifo_count) + int'(inflight)) < FIFO_DEPTH);

   // The start cycle itself issues the first read so the word lands in the queue
   // on the following edge; afterwards reads come from pc while credit allows.
   always_comb begin
      rd_issue   = 1'b0;
      fetch_addr = pc;
      if (state == IDLE) begin
         rd_issue   = start;
         fetch_addr = start_addr & ALIGN_MASK;
      end else begin
         rd_issue   = !flush && credit_ok;
      end
   end

   // Little-endian assembly; byte addresses wrap modulo 2^ADDR_W.
   always_comb begin
      fetch_word = '0;
      for (int i = 0; i < BYTE_W; i++) begin
         fetch_word[8*i +: 8] = mem[ADDR_W'(fetch_addr + ADDR_W'(i))];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= '0;
         inflight <= 1'b0;
         rd_word  <= '0;
         rd_pc    <= '0;
         busy     <= 1'b0;
      end else begin
         // A flush suppresses rd_issue, which also discards the in-flight read.
         inflight <= rd_issue;
         if (rd_issue) begin
            rd_word <= fetch_word;
            rd_pc   <= fetch_addr;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  pc    <= (start_addr & ALIGN_MASK) + STEP;
                  busy  <= 1'b1;
               end
            end
            RUN, REDIRECT: begin
               busy <= 1'b1;
               if (flush) begin
                  state <= REDIRECT;
                  pc    <= flush_addr & ALIGN_MASK;
               end else begin
                  state <= RUN;
                  if (rd_issue) begin
                     pc <= pc + STEP;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // A flush on the same edge as a handshake drops that entry.
   assign fifo_push = inflight && !flush_act;
   assign fifo_pop  = out_valid && out_ready && !flush_act;

   imem_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (fifo_push),
      .push_dat ({rd_pc, rd_word}),
      .pop      (fifo_pop),
      .clear    (flush_act),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Remember the last presented entry so the outputs hold while the queue is empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dat <= '0;
      end else if (!fifo_empty) begin
         last_dat <= head_dat;
      end
   end

   assign out_valid = !fifo_empty;
   assign shown_dat = fifo_empty ? last_dat : head_dat;
   assign out_instr = shown_dat[WORD_W-1:0];
   assign out_pc    = shown_dat[ENT_W-1:WORD_W];

endmodule

// File: tb/tb_instr_prefetch_mem.sv
// Directed bench for instr_prefetch_mem: latency, ordering, backpressure, flush, wrap, reset, loader.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_instr_prefetch_mem;
   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       start      = 1'b0;
   logic [7:0] start_addr = 8'h00;
   logic       flush      = 1'b0;
   logic [7:0] flush_addr = 8'h00;
   logic       out_ready  = 1'b0;
   logic       out_valid;
   logic [31:0] out_instr;
   logic [7:0] out_pc;
   logic       busy;
`ifdef IMEM_LOADER_EN
   logic       wr_en   = 1'b0;
   logic [7:0] wr_addr = 8'h00;
   logic [7:0] wr_byte = 8'h00;
`endif

   logic [7:0]  img [256];
   logic [7:0]  exp_pc;
   logic [7:0]  hold_pc;
   logic [31:0] hold_word;
   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_prefetch_mem #(
      .BYTE_W     (4),
      .ADDR_W     (8),
      .FIFO_DEPTH (4),
      .INIT_FILE  ("")
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .start_addr (start_addr),
      .flush      (flush),
      .flush_addr (flush_addr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .busy       (busy)
`ifdef IMEM_LOADER_EN
      ,
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_byte    (wr_byte)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [7:0] a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) begin
         w[8*i +: 8] = img[8'(a + 8'(i))];
      end
      return w;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   // Check the presented entry against the model, then let it transfer.
   task automatic beat(input string tag);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_pc"}, out_pc, exp_pc);
      check({tag, "_instr"}, out_instr, exp_word(exp_pc));
      exp_pc = exp_pc + 8'd4;
      tick();
   endtask

   task automatic wait_valid(input string tag, input int max_cycles);
      for (int n = 0; n < max_cycles && !out_valid; n++) begin
         tick();
      end
      check({tag, "_wait_valid"}, out_valid, 1'b1);
   endtask

   task automatic preload();
`ifdef IMEM_LOADER_EN
      for (int a = 0; a < 256; a++) begin
         wr_en   = 1'b1;
         wr_addr = 8'(a);
         wr_byte = img[a];
         tick();
      end
      wr_en = 1'b0;
`else
      for (int a = 0; a < 256; a++) begin
         dut.mem[a] = img[a];
      end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 256; a++) begin
         img[a] = 8'(a * 7 + 3);
      end
      img[0] = 8'h00;
      img[1] = 8'h10;
      img[2] = 8'h12;
      img[3] = 8'hE4;

      // Reset state
      repeat (3) tick();
      check("rst_valid", out_valid, 1'b0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_pc",    out_pc,    8'h00);
      check("rst_busy",  busy,      1'b0);
      rst_n = 1'b1;
      tick();
      preload();

      // First fetch latency and sequential delivery
      out_ready  = 1'b1;
      start_addr = 8'h00;
      start      = 1'b1;
      tick();
      start = 1'b0;
      check("lat_cycle1_valid", out_valid, 1'b0);
      check("lat_cycle1_busy",  busy,      1'b1);
      tick();
      check("lat_cycle2_instr", out_instr, 32'hE4121000);
      exp_pc = 8'h00;
      repeat (5) beat("seq");

      // Start while running is ignored
      start_addr = 8'h80;
      start      = 1'b1;
      beat("start_ign");
      start = 1'b0;
      repeat (3) beat("seq2");

      // Backpressure: queue fills to depth, pc stalls, head stays stable
      out_ready = 1'b0;
      hold_pc   = exp_pc;
      hold_word = exp_word(exp_pc);
      repeat (10) begin
         tick();
         check("bp_hold", {out_valid, out_instr, out_pc}, {1'b1, hold_word, hold_pc});
      end
      check("bp_count",    dut.u_fifo.count, 4);
      check("bp_pc_stall", dut.pc, 8'(hold_pc + 8'd16));
      out_ready = 1'b1;
      repeat (8) beat("bp_rel");

      // Flush with a coincident handshake: entry dropped, refetch from aligned target
      flush      = 1'b1;
      flush_addr = 8'h2E;
      tick();
      flush = 1'b0;
      check("fl_valid_drop", out_valid, 1'b0);
      check("fl_busy",       busy,      1'b1);
      exp_pc = 8'h2C;
      wait_valid("fl", 10);
      check("fl_first_pc", out_pc, 8'h2C);
      repeat (3) beat("fl_seq");

      // Reset mid-run with three words queued
      out_ready = 1'b0;
      tick();
      tick();
      check("mid_count3", dut.u_fifo.count, 3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy",  busy,      1'b0);
      check("mid_rst_out",   {out_instr, out_pc}, 40'h0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("mid_rst_state", dut.state, 2'd0);

      // Flush in IDLE is ignored
      flush      = 1'b1;
      flush_addr = 8'h40;
      tick();
      flush = 1'b0;
      tick();
      tick();
      check("idle_flush_busy",  busy,      1'b0);
      check("idle_flush_valid", out_valid, 1'b0);

      // Address wrap: FC, 00, 04; memory survived the reset
      out_ready  = 1'b1;
      start_addr = 8'hFC;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("wrap_word_hand", out_instr, 32'hFCF5EEE7);
      exp_pc = 8'hFC;
      repeat (3) beat("wrap");

`ifdef IMEM_LOADER_EN
      // Loader write accepted in IDLE, ignored during RUN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      wr_en   = 1'b1;
      wr_addr = 8'h03;
      wr_byte = 8'hAB;
      tick();
      wr_en  = 1'b0;
      img[3] = 8'hAB;
      start_addr = 8'h00;
      start      = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("ld_idle_byte", out_instr[31:24], 8'hAB);
      wr_en   = 1'b1;
      wr_byte = 8'hCD;
      tick();
      wr_en      = 1'b0;
      flush_addr = 8'h00;
      flush      = 1'b1;
      tick();
      flush = 1'b0;
      wait_valid("ld", 10);
      check("ld_run_ignored", out_instr[31:24], 8'hAB);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
